// File: rtl/i2c_sensor_frame_rx_pkg.sv
// Shared types and constants for the I2C sensor frame receiver.
package i2c_rx_pkg;

   localparam int unsigned ADDR_W = 7;

   // Entry 0 sits in the LSBs.
   localparam logic [3*ADDR_W-1:0] DEFAULT_ADDRS_C = {7'h7A, 7'h79, 7'h78};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_WAIT_STOP
   } fsm_state_e;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_START,
      EV_STOP
   } bus_event_e;

endpackage

// File: rtl/i2c_sensor_frame_rx_line_sync.sv
// SCL/SDA synchroniser with SCL-rise and START/STOP detection on the synchronised lines.
module i2c_line_sync
   import i2c_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       scl_rise,
   output logic       sda_s,
   output bus_event_e bus_evt
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   // SCL must be high on both samples so a simultaneous SCL fall is never a bus event.
   always_comb begin
      scl_rise = scl_s & ~scl_prev_q;
      bus_evt  = EV_NONE;
      if (scl_s && scl_prev_q && (sda_prev_q != sda_s)) begin
         bus_evt = sda_s ? EV_STOP : EV_START;
      end
   end

endmodule

// File: rtl/i2c_sensor_frame_rx.sv
// Multi-channel I2C frame snooper: address match against a programmable table,
// payload assembly, single-entry valid/ready output with overrun reporting.
module i2c_sensor_frame_rx
   import i2c_rx_pkg::*;
#(
   parameter int unsigned               NUM_CH        = 3,
   parameter int unsigned               FRAME_BYTES   = 6,
   parameter int unsigned               SYNC_STAGES   = 2,
   parameter logic [NUM_CH*ADDR_W-1:0]  DEFAULT_ADDRS = DEFAULT_ADDRS_C
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         scl,
   input  logic                         sda_in,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_CH)-1:0]    cfg_idx,
   input  logic [ADDR_W-1:0]            cfg_addr,
   output logic [FRAME_BYTES*8-1:0]     frame_data,
   output logic [$clog2(NUM_CH)-1:0]    frame_ch,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic                         frame_err,
   output logic                         overrun,
   input  logic                         clr_status,
   output logic                         busy
);

   localparam int unsigned CH_W = $clog2(NUM_CH);
   localparam int unsigned BC_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int unsigned FW   = FRAME_BYTES * 8;

   logic       scl_rise, sda_s;
   bus_event_e bus_evt;

   i2c_line_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .scl     (scl),
      .sda_in  (sda_in),
      .scl_rise(scl_rise),
      .sda_s   (sda_s),
      .bus_evt (bus_evt)
   );

   fsm_state_e                     state_q, state_d;
   logic [2:0]                     bit_cnt_q, bit_cnt_d;
   logic [BC_W-1:0]                byte_cnt_q, byte_cnt_d;
   logic [7:0]                     shift_q, shift_d;
   logic [FW-1:0]                  buf_q, buf_d;
   logic [CH_W-1:0]                ch_q, ch_d;
   logic [NUM_CH-1:0][ADDR_W-1:0]  addr_tab_q, addr_tab_d;
   logic [FW-1:0]                  frame_data_q, frame_data_d;
   logic [CH_W-1:0]                frame_ch_q, frame_ch_d;
   logic                           frame_valid_q, frame_valid_d;
   logic                           frame_err_q, frame_err_d;
   logic                           overrun_q, overrun_d;

   logic            match;
   logic [CH_W-1:0] match_ch;
   logic [7:0]      new_byte;
   logic            in_frame;
   logic            complete;
   logic            overrun_set;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      match    = 1'b0;
      match_ch = '0;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         if (addr_tab_q[i-1] == shift_q[7:1]) begin
            match    = 1'b1;
            match_ch = CH_W'(i - 1);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      shift_d       = shift_q;
      buf_d         = buf_q;
      ch_d          = ch_q;
      addr_tab_d    = addr_tab_q;
      frame_data_d  = frame_data_q;
      frame_ch_d    = frame_ch_q;
      frame_valid_d = frame_valid_q;
      frame_err_d   = 1'b0;
      overrun_d     = overrun_q;
      complete      = 1'b0;
      overrun_set   = 1'b0;
      new_byte      = {shift_q[6:0], sda_s};
      in_frame      = (state_q == ST_ADDR) || (state_q == ST_ADDR_ACK) ||
                      (state_q == ST_DATA) || (state_q == ST_DATA_ACK);

      if (cfg_we && (32'(cfg_idx) < NUM_CH)) begin
         addr_tab_d[cfg_idx] = cfg_addr;
      end

      if (bus_evt == EV_START) begin
         frame_err_d = in_frame;
         state_d     = ST_ADDR;
         bit_cnt_d   = '0;
      end else if (bus_evt == EV_STOP) begin
         frame_err_d = in_frame;
         state_d     = ST_IDLE;
      end else if (scl_rise) begin
         case (state_q)
            ST_ADDR: begin
               shift_d   = new_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
               if (!sda_s && shift_q[0] && match) begin
                  state_d    = ST_DATA;
                  ch_d       = match_ch;
                  byte_cnt_d = '0;
                  bit_cnt_d  = '0;
               end else begin
                  state_d = ST_WAIT_STOP;
               end
            end
            ST_DATA: begin
               shift_d   = new_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  for (int unsigned b = 0; b < FRAME_BYTES; b++) begin
                     if (byte_cnt_q == BC_W'(b)) buf_d[(FRAME_BYTES-1-b)*8 +: 8] = new_byte;
                  end
                  state_d = ST_DATA_ACK;
               end
            end
            ST_DATA_ACK: begin
               if (byte_cnt_q == BC_W'(FRAME_BYTES - 1)) begin
                  complete = 1'b1;
                  state_d  = ST_WAIT_STOP;
               end else if (!sda_s) begin
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
                  bit_cnt_d  = '0;
                  state_d    = ST_DATA;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_WAIT_STOP;
               end
            end
            default: ;
         endcase
      end

      if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;
      if (complete) begin
         if (!frame_valid_q || frame_ready) begin
            frame_data_d  = buf_q;
            frame_ch_d    = ch_q;
            frame_valid_d = 1'b1;
         end else begin
            overrun_set = 1'b1;
         end
      end
      if (clr_status) overrun_d = 1'b0;
      if (overrun_set) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         shift_q       <= '0;
         buf_q         <= '0;
         ch_q          <= '0;
         addr_tab_q    <= DEFAULT_ADDRS;
         frame_data_q  <= '0;
         frame_ch_q    <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         shift_q       <= shift_d;
         buf_q         <= buf_d;
         ch_q          <= ch_d;
         addr_tab_q    <= addr_tab_d;
         frame_data_q  <= frame_data_d;
         frame_ch_q    <= frame_ch_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign frame_data  = frame_data_q;
   assign frame_ch    = frame_ch_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_sensor_frame_rx.sv
// Directed bench for i2c_sensor_frame_rx: table of full transactions plus hand-written corner sequences.
module tb_i2c_sensor_frame_rx;

   localparam int Q = 4;

   logic        clk = 1'b0;
   logic        rst, scl, sda_in, cfg_we, frame_ready, clr_status;
   logic [1:0]  cfg_idx;
   logic [6:0]  cfg_addr;
   logic [47:0] frame_data;
   logic [1:0]  frame_ch;
   logic        frame_valid, frame_err, overrun, busy;

   i2c_sensor_frame_rx #(
      .NUM_CH     (3),
      .FRAME_BYTES(6),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .scl        (scl),
      .sda_in     (sda_in),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_addr   (cfg_addr),
      .frame_data (frame_data),
      .frame_ch   (frame_ch),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .clr_status (clr_status),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int          valid_cycles = 0, xfers = 0, err_cycles = 0, err_rises = 0, stab_viol = 0;
   logic [47:0] last_data = '0;
   logic [1:0]  last_ch = '0;
   logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
   logic [47:0] prev_data = '0;
   logic [1:0]  prev_ch = '0;

   always @(negedge clk) begin
      if (frame_valid) begin
         valid_cycles++;
         last_data = frame_data;
         last_ch   = frame_ch;
         if (frame_ready) xfers++;
      end
      if (prev_valid && !prev_ready && frame_valid &&
          ((frame_data != prev_data) || (frame_ch != prev_ch))) stab_viol++;
      if (frame_err) err_cycles++;
      if (frame_err && !prev_err) err_rises++;
      prev_valid = frame_valid;
      prev_ready = frame_ready;
      prev_data  = frame_data;
      prev_ch    = frame_ch;
      prev_err   = frame_err;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic hq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_in = 1'b1; hq();
      scl    = 1'b1; hq();
      sda_in = 1'b0; hq();
      scl    = 1'b0; hq();
   endtask

   task automatic i2c_stop();
      sda_in = 1'b0; hq();
      scl    = 1'b1; hq();
      sda_in = 1'b1; hq();
      hq();
   endtask

   task automatic i2c_bit(input logic b);
      sda_in = b;    hq();
      scl    = 1'b1; hq();
      scl    = 1'b0; hq();
   endtask

   task automatic i2c_byte(input logic [7:0] v, input logic ack);
      for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
      i2c_bit(ack);
   endtask

   task automatic send_frame(input logic [6:0] a, input logic rw, input logic aack,
                             input logic [47:0] d, input bit do_stop);
      i2c_start();
      i2c_byte({a, rw}, aack);
      for (int k = 0; k < 6; k++) i2c_byte(d[47-8*k -: 8], (k == 5));
      if (do_stop) i2c_stop();
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 frame_ready = v;
      @(negedge clk);
   endtask

   typedef struct {
      logic [6:0]  addr;
      logic        rw;
      logic        aack;
      logic [47:0] data;
      int          exp_frames;
      logic [1:0]  exp_ch;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int f0, e0, r0, x0;
      logic [47:0] d;

      vecs[0] = '{7'h78, 1'b1, 1'b0, 48'h112233445566, 1, 2'd0};
      vecs[1] = '{7'h7A, 1'b1, 1'b0, 48'hA1A2A3A4A5A6, 1, 2'd2};
      vecs[2] = '{7'h79, 1'b1, 1'b0, 48'hC0FFEE123456, 1, 2'd1};
      vecs[3] = '{7'h55, 1'b1, 1'b0, 48'hDEADBEEF0001, 0, 2'd0};
      vecs[4] = '{7'h78, 1'b0, 1'b0, 48'h0F0E0D0C0B0A, 0, 2'd0};
      vecs[5] = '{7'h79, 1'b1, 1'b1, 48'h5A5A5A5A5A5A, 0, 2'd0};

      rst = 1'b1; scl = 1'b1; sda_in = 1'b1; cfg_we = 1'b0; cfg_idx = '0;
      cfg_addr = '0; frame_ready = 1'b0; clr_status = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", frame_valid, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", frame_data, 0);
      chk("rst_ch", frame_ch, 0);

      // Basic 0x78 frame with completion-latency check on the final NACK.
      set_ready(1'b1);
      f0 = valid_cycles; e0 = err_cycles;
      d = 48'h010203040506;
      i2c_start();
      i2c_byte({7'h78, 1'b1}, 1'b0);
      for (int k = 0; k < 5; k++) i2c_byte(d[47-8*k -: 8], 1'b0);
      for (int i = 7; i >= 0; i--) i2c_bit(d[i]);
      sda_in = 1'b1; hq();
      scl = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("lat_before", frame_valid, 0);
      @(posedge clk); #1;
      chk("lat_valid", frame_valid, 1);
      chk("lat_data", frame_data, 48'h010203040506);
      chk("lat_ch", frame_ch, 0);
      @(posedge clk); #1;
      chk("valid_one_cycle", frame_valid, 0);
      @(negedge clk); hq();
      scl = 1'b0; hq();
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("basic_frames", valid_cycles - f0, 1);
      chk("basic_errs", err_cycles - e0, 0);

      for (int i = 0; i < 6; i++) begin
         f0 = valid_cycles; e0 = err_cycles;
         send_frame(vecs[i].addr, vecs[i].rw, vecs[i].aack, vecs[i].data, 1'b0);
         chk($sformatf("v%0d_busy_pre_stop", i), busy, 1);
         i2c_stop();
         repeat (8) @(negedge clk);
         chk($sformatf("v%0d_busy_idle", i), busy, 0);
         chk($sformatf("v%0d_frames", i), valid_cycles - f0, vecs[i].exp_frames);
         chk($sformatf("v%0d_errs", i), err_cycles - e0, 0);
         if (vecs[i].exp_frames != 0) begin
            chk($sformatf("v%0d_data", i), last_data, vecs[i].data);
            chk($sformatf("v%0d_ch", i), last_ch, vecs[i].exp_ch);
         end
      end

      // Backpressure: second frame dropped, overrun sticky until cleared.
      set_ready(1'b0);
      send_frame(7'h7A, 1'b1, 1'b0, 48'h111111222222, 1'b1);
      repeat (8) @(negedge clk);
      chk("bp_overrun_first", overrun, 0);
      send_frame(7'h79, 1'b1, 1'b0, 48'h333333444444, 1'b1);
      repeat (8) @(negedge clk);
      chk("bp_valid_held", frame_valid, 1);
      chk("bp_ch", frame_ch, 2);
      chk("bp_data", frame_data, 48'h111111222222);
      chk("bp_overrun", overrun, 1);
      chk("bp_stable", stab_viol, 0);
      x0 = xfers;
      @(posedge clk); #1 frame_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_drop", frame_valid, 0);
      repeat (4) @(negedge clk);
      chk("bp_xfers", xfers - x0, 1);
      chk("bp_overrun_sticky", overrun, 1);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      @(negedge clk);
      chk("bp_overrun_clr", overrun, 0);

      // Reprogram entry 1 to 0x55; 0x79 no longer matches.
      cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 7'h55;
      @(negedge clk);
      cfg_we = 1'b0;
      f0 = valid_cycles;
      send_frame(7'h55, 1'b1, 1'b0, 48'h5500AA11BB22, 1'b1);
      repeat (8) @(negedge clk);
      chk("cfg_frames", valid_cycles - f0, 1);
      chk("cfg_ch", last_ch, 1);
      chk("cfg_data", last_data, 48'h5500AA11BB22);
      f0 = valid_cycles;
      send_frame(7'h79, 1'b1, 1'b0, 48'h777777777777, 1'b1);
      repeat (8) @(negedge clk);
      chk("cfg_old_ignored", valid_cycles - f0, 0);

      // NACK after third byte aborts with a single error pulse.
      f0 = valid_cycles; e0 = err_cycles; r0 = err_rises;
      i2c_start();
      i2c_byte({7'h78, 1'b1}, 1'b0);
      i2c_byte(8'hAA, 1'b0);
      i2c_byte(8'hBB, 1'b0);
      i2c_byte(8'hCC, 1'b1);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("nack_err_cycles", err_cycles - e0, 1);
      chk("nack_err_pulses", err_rises - r0, 1);
      chk("nack_no_frame", valid_cycles - f0, 0);
      f0 = valid_cycles; e0 = err_cycles;
      send_frame(7'h78, 1'b1, 1'b0, 48'hFEDCBA987654, 1'b1);
      repeat (8) @(negedge clk);
      chk("after_nack_frames", valid_cycles - f0, 1);
      chk("after_nack_data", last_data, 48'hFEDCBA987654);
      chk("after_nack_errs", err_cycles - e0, 0);

      // Repeated START after byte 2, then a complete frame on channel 2.
      f0 = valid_cycles; e0 = err_cycles; r0 = err_rises;
      i2c_start();
      i2c_byte({7'h7A, 1'b1}, 1'b0);
      i2c_byte(8'h01, 1'b0);
      i2c_byte(8'h02, 1'b0);
      send_frame(7'h7A, 1'b1, 1'b0, 48'h0A0B0C0D0E0F, 1'b1);
      repeat (8) @(negedge clk);
      chk("rs_err_cycles", err_cycles - e0, 1);
      chk("rs_err_pulses", err_rises - r0, 1);
      chk("rs_frames", valid_cycles - f0, 1);
      chk("rs_ch", last_ch, 2);
      chk("rs_data", last_data, 48'h0A0B0C0D0E0F);

      // Reset mid-byte with a held frame and overrun pending.
      set_ready(1'b0);
      send_frame(7'h7A, 1'b1, 1'b0, 48'h123456789ABC, 1'b1);
      send_frame(7'h78, 1'b1, 1'b0, 48'h000000000001, 1'b1);
      repeat (8) @(negedge clk);
      chk("pre_rst_valid", frame_valid, 1);
      chk("pre_rst_overrun", overrun, 1);
      e0 = err_cycles;
      i2c_start();
      i2c_byte({7'h78, 1'b1}, 1'b0);
      i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", frame_valid, 0);
      chk("mid_rst_data", frame_data, 0);
      chk("mid_rst_ch", frame_ch, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_busy", busy, 0);
      i2c_stop();
      repeat (8) @(negedge clk);
      chk("mid_rst_no_err", err_cycles - e0, 0);
      chk("mid_rst_idle", busy, 0);
      set_ready(1'b1);
      f0 = valid_cycles;
      send_frame(7'h79, 1'b1, 1'b0, 48'hCAFEF00D0102, 1'b1);
      repeat (8) @(negedge clk);
      chk("tab_reset_frames", valid_cycles - f0, 1);
      chk("tab_reset_ch", last_ch, 1);
      chk("tab_reset_data", last_data, 48'hCAFEF00D0102);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
